muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage.
// Each clock performs one shift-add (multiply) or one restoring-divide step.
// Ports:
//   clk, reset     - clock and synchronous active-high reset
//   start, flush   - issue strobe (accepted only in IDLE); synchronous abort
//   Funct3         - RV32M operation select
//   SrcA, SrcB     - rs1 / rs2 operands
//   busy           - operation in flight, EX must stall
//   done           - one-cycle pulse, Result valid
//   Result         - registered result, held until the next done
module muldiv_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  flush,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] Result
);
  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned ACC_W = 2 * W + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [W-1:0]         opnd_q, opnd_d;
  logic [2:0]           op_q, op_d;
  logic                 neg_q, neg_d;
  logic                 rem_neg_q, rem_neg_d;
  logic                 special_q, special_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [W-1:0]         result_q, result_d;

  // Issue-time decode: signedness, magnitudes and special-case detection
  logic         is_div, sgn_a, sgn_b, neg_a, neg_b, div_zero, div_ovf;
  logic [W-1:0] abs_a, abs_b, spec_res;
  always_comb begin
    is_div   = Funct3[2];
    sgn_a    = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
               (Funct3 == 3'b100) || (Funct3 == 3'b110);
    sgn_b    = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    neg_a    = sgn_a & SrcA[W-1];
    neg_b    = sgn_b & SrcB[W-1];
    abs_a    = neg_a ? -SrcA : SrcA;
    abs_b    = neg_b ? -SrcB : SrcB;
    div_zero = is_div && (SrcB == '0);
    // Only the signed ops (DIV/REM have Funct3[0]==0) can overflow
    div_ovf  = is_div && !Funct3[0] && (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
    if (div_zero) spec_res = Funct3[1] ? SrcA : '1;
    else          spec_res = Funct3[1] ? '0 : SrcA;
  end

  // One iteration of each algorithm.
  // Multiply: acc = {upper partial product (W+1), multiplier (W)}.
  // Divide:   acc = {remainder (W+1), dividend/quotient (W)}.
  logic [W:0]       mul_hi;
  logic [W+1:0]     trial;
  logic [ACC_W-1:0] mul_next, div_next;
  always_comb begin
    mul_hi = acc_q[ACC_W-1:W];
    if (acc_q[0]) mul_hi = mul_hi + {1'b0, opnd_q};
    mul_next = {1'b0, mul_hi, acc_q[W-1:1]};
    // Trial subtract on the left-shifted remainder; MSB of trial is the borrow
    trial = {1'b0, acc_q[ACC_W-2:W-1]} - {2'b00, opnd_q};
    if (!trial[W+1]) div_next = {trial[W:0], acc_q[W-2:0], 1'b1};
    else             div_next = {acc_q[ACC_W-2:0], 1'b0};
  end

  // Sign correction and half/quotient/remainder selection
  logic [2*W-1:0] prod_fix;
  logic [W-1:0]   quo_fix, rem_fix, fix_res;
  always_comb begin
    prod_fix = neg_q ? -acc_q[2*W-1:0] : acc_q[2*W-1:0];
    quo_fix  = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
    rem_fix  = rem_neg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    if (special_q)                fix_res = acc_q[W-1:0];
    else if (op_q[2])             fix_res = op_q[1] ? rem_fix : quo_fix;
    else if (op_q[1:0] == 2'b00)  fix_res = prod_fix[W-1:0];
    else                          fix_res = prod_fix[2*W-1:W];
  end

  // Next-state and register updates
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    special_d = special_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d      = Funct3;
          neg_d     = neg_a ^ neg_b;
          rem_neg_d = neg_a;
          cnt_d     = '0;
          busy_d    = 1'b1;
          if (div_zero || div_ovf) begin
            special_d = 1'b1;
            acc_d     = {{(W+1){1'b0}}, spec_res};
            opnd_d    = '0;
            state_d   = FIX;
          end else begin
            special_d = 1'b0;
            acc_d     = {{(W+1){1'b0}}, is_div ? abs_a : abs_b};
            opnd_d    = is_div ? abs_b : abs_a;
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        acc_d = op_q[2] ? div_next : mul_next;
        if (cnt_q == CNT_WIDTH'(W - 1)) state_d = FIX;
      end
      FIX: begin
        result_d = fix_res;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a same-cycle start
    if (flush) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      special_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      special_q <= special_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign Result = result_q;

endmodule
